// File: rtl/uart_pkg.sv
// Shared definitions for the one-bit-per-clock UART link (transmitter and receiver).
package uart_pkg;
    localparam int BITS_W                = 6;
    localparam int DEFAULT_MAX_WORD_SIZE = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } state_t;

    // A zero or oversize count becomes a full word so the receiver's bit compare stays valid.
    function automatic logic [BITS_W-1:0] clamp_bits(input logic [BITS_W-1:0] bits,
                                                     input logic [BITS_W-1:0] max_bits);
        return (bits == '0 || bits > max_bits) ? max_bits : bits;
    endfunction
endpackage

// File: rtl/uart_tx_shifter.sv
// Frame shifter: data shift register plus data-bit and stop-cycle counters.
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int MAX_WORD_SIZE = DEFAULT_MAX_WORD_SIZE,
    parameter int STOP_BITS     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [MAX_WORD_SIZE-1:0] load_data,
    input  logic [BITS_W-1:0]        load_bits,
    input  logic                     shift,
    input  logic                     cnt_inc,
    input  logic                     stop_inc,
    output logic                     bit0,
    output logic                     end_data,
    output logic                     stop_pre_last,
    output logic                     end_stop
);
    localparam int SW = $clog2(STOP_BITS);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);
    localparam logic [SW-1:0] STOP_PRE  = SW'(STOP_BITS - 2);

    logic [MAX_WORD_SIZE-1:0] shift_reg;
    logic [BITS_W-1:0]        frame_bits;
    logic [BITS_W-1:0]        bit_cnt;
    logic [SW-1:0]            stop_cnt;

    // The frame length is latched here because the holding register may already
    // carry the next word's count while this frame is still shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            frame_bits <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
        end else if (load) begin
            shift_reg  <= load_data;
            frame_bits <= load_bits;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
        end else begin
            if (shift)    shift_reg <= shift_reg >> 1;
            if (cnt_inc)  bit_cnt   <= bit_cnt + BITS_W'(1);
            if (stop_inc) stop_cnt  <= stop_cnt + SW'(1);
        end
    end

    assign bit0          = shift_reg[0];
    assign end_data      = (bit_cnt == frame_bits - BITS_W'(1));
    assign stop_pre_last = (stop_cnt == STOP_PRE);
    assign end_stop      = (stop_cnt == STOP_LAST);
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one line bit per clock, one-word holding register, registered tx/tx_done.
module uart_tx
    import uart_pkg::*;
#(
    parameter int MAX_WORD_SIZE = DEFAULT_MAX_WORD_SIZE,
    parameter int STOP_BITS     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [MAX_WORD_SIZE-1:0] din,
    input  logic [BITS_W-1:0]        tx_bits,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic                     tx,
    output logic                     tx_done,
    output logic                     busy
);
    localparam logic [BITS_W-1:0] MAX_BITS = BITS_W'(MAX_WORD_SIZE);

    state_t                   state;
    logic [MAX_WORD_SIZE-1:0] hold_data;
    logic [BITS_W-1:0]        hold_bits;
    logic                     hold_valid;

    logic accept, load, shift, cnt_inc, stop_inc;
    logic bit0, end_data, stop_pre_last, end_stop;

    assign din_ready = !hold_valid;
    assign busy      = (state != IDLE) || hold_valid;
    assign accept    = din_valid && din_ready;

    // The shifter reloads either from idle or straight out of the last stop cycle.
    assign load     = hold_valid && (state == IDLE || (state == STOP && end_stop));
    assign shift    = (state == START) || (state == DATA && !end_data);
    assign cnt_inc  = (state == DATA) && !end_data;
    assign stop_inc = (state == STOP) && !end_stop;

    uart_tx_shifter #(
        .MAX_WORD_SIZE (MAX_WORD_SIZE),
        .STOP_BITS     (STOP_BITS)
    ) u_shifter (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .load_data     (hold_data),
        .load_bits     (hold_bits),
        .shift         (shift),
        .cnt_inc       (cnt_inc),
        .stop_inc      (stop_inc),
        .bit0          (bit0),
        .end_data      (end_data),
        .stop_pre_last (stop_pre_last),
        .end_stop      (end_stop)
    );

    // tx is registered with the level of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_bits  <= '0;
        end else begin
            tx_done <= (state == STOP) && stop_pre_last;
            if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= din;
                hold_bits  <= clamp_bits(tx_bits, MAX_BITS);
            end
            case (state)
                IDLE: begin
                    if (hold_valid) begin
                        hold_valid <= 1'b0;
                        state      <= START;
                        tx         <= 1'b0;
                    end
                end
                START: begin
                    state <= DATA;
                    tx    <= bit0;
                end
                DATA: begin
                    if (end_data) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        tx <= bit0;
                    end
                end
                STOP: begin
                    if (end_stop) begin
                        if (hold_valid) begin
                            hold_valid <= 1'b0;
                            state      <= START;
                            tx         <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
